// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if : fetch-side and execute-side signal bundle of decode_stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             if_valid;
  logic             if_ready;
  logic [31:0]      if_instr;
  logic [XLEN-1:0]  if_pc;
  logic             id_valid;
  logic             id_ready;
  logic [XLEN-1:0]  id_pc;
  logic             id_reg_wen;
  logic [4:0]       id_reg_waddr;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             id_sel_imm;
  logic             id_sel_pc;
  logic [3:0]       id_alu_op;
  logic [2:0]       id_mem_rd_op;
  logic [1:0]       id_mem_wr_op;
  logic [2:0]       id_branch_op;
  logic             id_br_instr;
  logic             id_jal;
  logic             id_jalr;
  logic [XLEN-1:0]  id_imm;
  logic             id_ill_instr;
  logic             id_md_instr;
  logic [2:0]       id_md_op;
  logic [CNT_W-1:0] ill_count;

  modport master (
    output flush, if_valid, if_instr, if_pc, id_ready,
    input  if_ready, id_valid, id_pc, id_reg_wen, id_reg_waddr, id_rs1_addr,
           id_rs2_addr, id_rs1_used, id_rs2_used, id_sel_imm, id_sel_pc,
           id_alu_op, id_mem_rd_op, id_mem_wr_op, id_branch_op, id_br_instr,
           id_jal, id_jalr, id_imm, id_ill_instr, id_md_instr, id_md_op,
           ill_count
  );

  modport slave (
    input  flush, if_valid, if_instr, if_pc, id_ready,
    output if_ready, id_valid, id_pc, id_reg_wen, id_reg_waddr, id_rs1_addr,
           id_rs2_addr, id_rs1_used, id_rs2_used, id_sel_imm, id_sel_pc,
           id_alu_op, id_mem_rd_op, id_mem_wr_op, id_branch_op, id_br_instr,
           id_jal, id_jalr, id_imm, id_ill_instr, id_md_instr, id_md_op,
           ill_count
  );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage : RV32I decode into an ID/EX register with valid/ready, flush
//                and a saturating illegal-instruction counter.
//                Define CORE_RV32M_EN to accept M-extension OP encodings.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_MISC   = 7'b0001111;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

  // No-op memory encodings are func3 values that no legal load/store uses
  localparam logic [2:0]       c_MEM_NO_RD = 3'b111;
  localparam logic [1:0]       c_MEM_NO_WR = 2'b11;
  localparam logic [3:0]       c_ALU_ADD   = 4'b0000;
  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

  logic [31:0]     w_inst;
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_accept;
  logic            w_reg_wen;
  logic [4:0]      w_rs1_addr;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_sel_imm;
  logic            w_sel_pc;
  logic [3:0]      w_alu_op;
  logic [2:0]      w_mem_rd;
  logic [1:0]      w_mem_wr;
  logic            w_br;
  logic            w_jal;
  logic            w_jalr;
  logic            w_ill;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
`ifdef CORE_RV32M_EN
  logic            w_md;
  logic [2:0]      w_md_op;
  logic            r_md;
  logic [2:0]      r_md_op;
`endif

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic             r_reg_wen;
  logic [4:0]       r_waddr;
  logic [4:0]       r_rs1_addr;
  logic [4:0]       r_rs2_addr;
  logic             r_rs1_used;
  logic             r_rs2_used;
  logic             r_sel_imm;
  logic             r_sel_pc;
  logic [3:0]       r_alu_op;
  logic [2:0]       r_mem_rd;
  logic [1:0]       r_mem_wr;
  logic [2:0]       r_br_op;
  logic             r_br;
  logic             r_jal;
  logic             r_jalr;
  logic [XLEN-1:0]  r_imm;
  logic             r_ill;
  logic [CNT_W-1:0] r_ill_cnt;

  assign w_inst   = bus.if_instr;
  assign w_opc    = w_inst[6:0];
  assign w_f3     = w_inst[14:12];
  assign w_f7     = w_inst[31:25];
  assign w_accept = bus.if_valid && bus.if_ready;

  always_comb begin
    w_reg_wen  = 1'b0;
    w_rs1_addr = w_inst[19:15];
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_sel_imm  = 1'b0;
    w_sel_pc   = 1'b0;
    w_alu_op   = c_ALU_ADD;
    w_mem_rd   = c_MEM_NO_RD;
    w_mem_wr   = c_MEM_NO_WR;
    w_br       = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_ill      = 1'b0;
    w_imm32    = 32'd0;
`ifdef CORE_RV32M_EN
    w_md       = 1'b0;
    w_md_op    = 3'b000;
`endif
    case (w_opc)
      c_OPC_LOAD: begin
        w_reg_wen  = 1'b1;
        w_rs1_used = 1'b1;
        w_sel_imm  = 1'b1;
        w_mem_rd   = w_f3;
        w_imm32    = {{20{w_inst[31]}}, w_inst[31:20]};
        w_ill      = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      c_OPC_STORE: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_sel_imm  = 1'b1;
        w_mem_wr   = w_f3[1:0];
        w_imm32    = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
        w_ill      = w_f3[2] || (w_f3[1:0] == 2'b11);
      end
      c_OPC_BRANCH: begin
        w_br       = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm32    = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
        w_ill      = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      c_OPC_OPIMM: begin
        w_reg_wen  = 1'b1;
        w_rs1_used = 1'b1;
        w_sel_imm  = 1'b1;
        // Only shifts carry a func7 field; for other ops bit 30 is immediate data
        w_alu_op   = {(w_f3 == 3'b101) && w_inst[30], w_f3};
        w_imm32    = {{20{w_inst[31]}}, w_inst[31:20]};
        if (w_f3 == 3'b001)
          w_ill = (w_f7 != 7'b0000000);
        else if (w_f3 == 3'b101)
          w_ill = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
      end
      c_OPC_OP: begin
        w_reg_wen  = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_alu_op   = {w_inst[30], w_f3};
        if (w_f7 == 7'b0000000) begin
          w_ill = 1'b0;
        end else if (w_f7 == 7'b0100000) begin
          w_ill = (w_f3 != 3'b000) && (w_f3 != 3'b101);
`ifdef CORE_RV32M_EN
        end else if (w_f7 == 7'b0000001) begin
          w_md     = 1'b1;
          w_md_op  = w_f3;
          w_alu_op = c_ALU_ADD;
`endif
        end else begin
          w_ill = 1'b1;
        end
      end
      c_OPC_LUI: begin
        w_reg_wen  = 1'b1;
        w_sel_imm  = 1'b1;
        w_rs1_addr = 5'd0;
        w_imm32    = {w_inst[31:12], 12'd0};
      end
      c_OPC_AUIPC: begin
        w_reg_wen = 1'b1;
        w_sel_imm = 1'b1;
        w_sel_pc  = 1'b1;
        w_imm32   = {w_inst[31:12], 12'd0};
      end
      c_OPC_JAL: begin
        w_reg_wen = 1'b1;
        w_jal     = 1'b1;
        w_sel_pc  = 1'b1;
        w_sel_imm = 1'b1;
        w_imm32   = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
      end
      c_OPC_JALR: begin
        w_reg_wen  = 1'b1;
        w_jalr     = 1'b1;
        w_rs1_used = 1'b1;
        w_sel_imm  = 1'b1;
        w_imm32    = {{20{w_inst[31]}}, w_inst[31:20]};
        w_ill      = (w_f3 != 3'b000);
      end
      c_OPC_MISC: begin
        w_ill = 1'b0;
      end
      default: begin
        w_ill = 1'b1;
      end
    endcase

    // An illegal instruction must not produce any architectural side effect
    if (w_ill) begin
      w_reg_wen = 1'b0;
      w_mem_rd  = c_MEM_NO_RD;
      w_mem_wr  = c_MEM_NO_WR;
      w_br      = 1'b0;
      w_jal     = 1'b0;
      w_jalr    = 1'b0;
`ifdef CORE_RV32M_EN
      w_md      = 1'b0;
`endif
    end
  end

  generate
    if (XLEN > 32) begin : g_imm_ext
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_narrow
      assign w_imm = w_imm32;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_reg_wen  <= 1'b0;
      r_waddr    <= 5'd0;
      r_rs1_addr <= 5'd0;
      r_rs2_addr <= 5'd0;
      r_rs1_used <= 1'b0;
      r_rs2_used <= 1'b0;
      r_sel_imm  <= 1'b0;
      r_sel_pc   <= 1'b0;
      r_alu_op   <= 4'd0;
      r_mem_rd   <= c_MEM_NO_RD;
      r_mem_wr   <= c_MEM_NO_WR;
      r_br_op    <= 3'd0;
      r_br       <= 1'b0;
      r_jal      <= 1'b0;
      r_jalr     <= 1'b0;
      r_imm      <= '0;
      r_ill      <= 1'b0;
`ifdef CORE_RV32M_EN
      r_md       <= 1'b0;
      r_md_op    <= 3'd0;
`endif
    end else if (bus.flush || (!w_accept && bus.id_ready)) begin
      // Invalidate: only side-effecting controls are cleared, data goes stale
      r_valid   <= 1'b0;
      r_reg_wen <= 1'b0;
      r_mem_rd  <= c_MEM_NO_RD;
      r_mem_wr  <= c_MEM_NO_WR;
      r_br      <= 1'b0;
      r_jal     <= 1'b0;
      r_jalr    <= 1'b0;
      r_ill     <= 1'b0;
`ifdef CORE_RV32M_EN
      r_md      <= 1'b0;
`endif
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= bus.if_pc;
      r_reg_wen  <= w_reg_wen;
      r_waddr    <= w_inst[11:7];
      r_rs1_addr <= w_rs1_addr;
      r_rs2_addr <= w_inst[24:20];
      r_rs1_used <= w_rs1_used;
      r_rs2_used <= w_rs2_used;
      r_sel_imm  <= w_sel_imm;
      r_sel_pc   <= w_sel_pc;
      r_alu_op   <= w_alu_op;
      r_mem_rd   <= w_mem_rd;
      r_mem_wr   <= w_mem_wr;
      r_br_op    <= w_f3;
      r_br       <= w_br;
      r_jal      <= w_jal;
      r_jalr     <= w_jalr;
      r_imm      <= w_imm;
      r_ill      <= w_ill;
`ifdef CORE_RV32M_EN
      r_md       <= w_md;
      r_md_op    <= w_md_op;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ill_cnt <= '0;
    end else if (w_accept && !bus.flush && w_ill && (r_ill_cnt != c_CNT_MAX)) begin
      r_ill_cnt <= r_ill_cnt + 1'b1;
    end
  end

  assign bus.if_ready     = !r_valid || bus.id_ready || bus.flush;
  assign bus.id_valid     = r_valid;
  assign bus.id_pc        = r_pc;
  assign bus.id_reg_wen   = r_reg_wen;
  assign bus.id_reg_waddr = r_waddr;
  assign bus.id_rs1_addr  = r_rs1_addr;
  assign bus.id_rs2_addr  = r_rs2_addr;
  assign bus.id_rs1_used  = r_rs1_used;
  assign bus.id_rs2_used  = r_rs2_used;
  assign bus.id_sel_imm   = r_sel_imm;
  assign bus.id_sel_pc    = r_sel_pc;
  assign bus.id_alu_op    = r_alu_op;
  assign bus.id_mem_rd_op = r_mem_rd;
  assign bus.id_mem_wr_op = r_mem_wr;
  assign bus.id_branch_op = r_br_op;
  assign bus.id_br_instr  = r_br;
  assign bus.id_jal       = r_jal;
  assign bus.id_jalr      = r_jalr;
  assign bus.id_imm       = r_imm;
  assign bus.id_ill_instr = r_ill;
  assign bus.ill_count    = r_ill_cnt;
`ifdef CORE_RV32M_EN
  assign bus.id_md_instr  = r_md;
  assign bus.id_md_op     = r_md_op;
`else
  assign bus.id_md_instr  = 1'b0;
  assign bus.id_md_op     = 3'b000;
`endif

endmodule

`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered instruction-decode stage for the veriRISCV core pipeline, sitting between fetch and execute. Decodes the full RV32I base opcode map into datapath control and an XLEN-wide immediate (I/S/B/U/J formats). Holds the result in an ID/EX pipeline register with a valid/ready handshake, flush and a saturating illegal-instruction counter.

Parameters:
XLEN, 32, datapath width; immediates sign-extended to XLEN; legal values 32 or 64.
CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
flush  input  1  kill ID/EX content and any beat accepted this cycle
if_valid  input  1  fetch beat valid
if_ready  output  1  stage can accept a beat
if_instr  input  32  instruction word
if_pc  input  XLEN  instruction PC
id_valid  output  1  ID/EX register holds a live instruction
id_ready  input  1  execute accepts the ID/EX content
id_pc  output  XLEN  registered PC
id_reg_wen  output  1  write rd
id_reg_waddr / id_rs1_addr / id_rs2_addr  output  5 each  rd/rs1/rs2 (rs1 forced 0 for LUI)
id_rs1_used / id_rs2_used  output  1 each  operand actually read (hazard unit)
id_sel_imm  output  1  ALU operand B = immediate
id_sel_pc  output  1  ALU operand A = PC (AUIPC, JAL)
id_alu_op  output  4  {func7[5],func3} encoding; ADD for non-ALU ops
id_mem_rd_op  output  3  load func3, or CORE_MEM_NO_RD
id_mem_wr_op  output  2  store func3[1:0], or CORE_MEM_NO_WR
id_branch_op  output  3  branch func3
id_br_instr / id_jal / id_jalr  output  1 each  control-transfer type
id_imm  output  XLEN  sign-extended immediate
id_ill_instr  output  1  illegal instruction
id_md_instr  output  1  M-extension op
id_md_op  output  3  M-extension func3
ill_count  output  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous and active-high.
- Reset: id_valid=0, ill_count=0, all id_* control/data outputs 0; mem ops reset to NO_RD/NO_WR encodings.
- if_ready = !id_valid | id_ready | flush (combinational). Accept = if_valid & if_ready.
- Latency: decode is combinational on if_instr; results visible on id_* one cycle after accept.
- Accept & !flush: load ID/EX, id_valid<=1. No accept & id_ready: id_valid<=0. Stall (id_valid & !id_ready): all id_* hold.
- Flush: id_valid<=0 next cycle; a beat accepted in the same cycle is dropped and not counted. Flush wins over accept. rst wins over flush.
- On id_valid<=0, clear id_reg_wen, id_br_instr, id_jal, id_jalr, id_ill_instr; set mem ops to NO_RD/NO_WR. Data fields may hold stale values.
- Opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, MISC-MEM (FENCE decodes as NOP, legal). SYSTEM and all other opcodes are illegal.
- JAL/JALR: reg_wen=1. JAL: sel_pc=1, sel_imm=1. JALR: sel_imm=1; func3!=000 is illegal.
- Illegal cases:
  - LOAD func3 011/110/111.
  - STORE func3[2]=1 or 011.
  - BRANCH func3 010/011.
  - OP-IMM func3 001 with func7!=0; func3 101 with func7 not 0000000/0100000.
  - OP with func7 not 0000000, or 0100000 only with func3 000/101; 0000001 only legal under the macro.
- Illegal instruction: id_ill_instr=1; reg_wen, mem ops, br/jal/jalr, md_instr forced inactive.
- Immediate formats:
  - I = inst[31:20].
  - S = {inst[31:25],inst[11:7]}.
  - B = {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U = {inst[31:12],12'b0}.
  - J = {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - All formats sign-extended from bit 31 to XLEN.
- ill_count: +1 per accepted, non-flushed illegal beat. Saturates at 2^CNT_W-1, never wraps.

Optional Feature:
CORE_RV32M_EN: defined -> OP with func7=0000001 is legal; id_md_instr=1, id_md_op=func3, reg_wen=1. Undefined -> these encodings are illegal; id_md_instr/id_md_op tied 0.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), id_ready=1 -> next cycle id_valid=1, reg_wen=1, waddr=1, sel_imm=1, alu_op=0000, imm=0xFFFFFFFF.
- BEQ x0,x0,-4 (0xFE000EE3) -> br_instr=1, branch_op=000, imm=0xFFFFFFFC, reg_wen=0; LUI x5 (0x123452B7) -> imm=0x12345000, rs1_addr=0.
- Accept beat then hold id_ready=0 for 3 cycles -> if_ready=0, all id_* stable; id_ready=1 -> next beat accepted same cycle.
- flush asserted in the same cycle as accepting 0x00000000 -> id_valid=0 next cycle, ill_count stays 0.
- Four accepted 0x00000000 beats, CNT_W=2 -> id_ill_instr=1, reg_wen=0 each time; ill_count = 1,2,3,3 (saturated).
- MUL x3,x1,x2 (0x022081B3): with CORE_RV32M_EN -> md_instr=1, md_op=000, ill=0; without -> ill_instr=1, ill_count increments.
